// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, in-order IMEM requests with a credit-limited prefetch FIFO,
// fetch/decode register, stall hold and redirect squashing. Optional macro: FETCH_MISALIGN_CHK_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_RDY,
   input  logic        IMEM_VALID,
   input  logic [31:0] IMEM_RDATA,
   input  logic        STALL_D,
   input  logic        BRN_TAKEN,
   input  logic [31:0] BRN_TARGET,
   output logic [31:0] InstrD,
   output logic [31:0] PC_DE,
`ifdef FETCH_MISALIGN_CHK_EN
   output logic        MISALIGN_D,
`endif
   output logic        VALID_D
);

   localparam int unsigned PtrW     = $clog2(BUF_DEPTH);
   localparam int unsigned CntW     = $clog2(BUF_DEPTH + 1);
   localparam logic [31:0] NopInstr = 32'h0000_0013;
   localparam logic [CntW:0] Credits = (CntW + 1)'(BUF_DEPTH);

   logic [31:0]     pc_f_q, pc_f_d;
   logic [31:0]     addr_mem_q [BUF_DEPTH];
   logic [31:0]     addr_mem_d [BUF_DEPTH];
   logic [PtrW-1:0] addr_wr_q, addr_wr_d, addr_rd_q, addr_rd_d;
   logic [31:0]     ib_pc_q [BUF_DEPTH];
   logic [31:0]     ib_pc_d [BUF_DEPTH];
   logic [31:0]     ib_instr_q [BUF_DEPTH];
   logic [31:0]     ib_instr_d [BUF_DEPTH];
   logic [PtrW-1:0] ib_wr_q, ib_wr_d, ib_rd_q, ib_rd_d;
   logic [CntW-1:0] ib_cnt_q, ib_cnt_d;
   logic [CntW-1:0] in_flight_q, in_flight_d;
   logic [CntW-1:0] drop_q, drop_d;
   logic [31:0]     dec_instr_q, dec_instr_d;
   logic [31:0]     dec_pc_q, dec_pc_d;
   logic            dec_valid_q, dec_valid_d;

   logic        issue, accept, resp, resp_drop, resp_keep, ib_empty;
   logic        dec_load, dec_from_fifo, dec_bypass, dec_real, ib_push, ib_pop;
   logic [31:0] dec_src_pc, dec_src_instr;

   always_comb begin
      issue     = !rst && !BRN_TAKEN && (({1'b0, in_flight_q} + {1'b0, ib_cnt_q}) < Credits);
      accept    = issue && IMEM_RDY;
      // Responses left over from before a reset are untracked and ignored.
      resp      = IMEM_VALID && (in_flight_q != '0);
      resp_drop = resp && (BRN_TAKEN || (drop_q != '0));
      resp_keep = resp && !resp_drop;
      ib_empty  = (ib_cnt_q == '0);
      dec_load  = !BRN_TAKEN && !STALL_D;
      dec_from_fifo = dec_load && !ib_empty;
      // An empty FIFO lets a fresh response go straight to decode (latency = mem + 1).
      dec_bypass    = dec_load && ib_empty && resp_keep;
      dec_real      = dec_from_fifo || dec_bypass;
      ib_push       = resp_keep && !dec_bypass;
      ib_pop        = dec_from_fifo;
      dec_src_pc    = dec_from_fifo ? ib_pc_q[ib_rd_q] : addr_mem_q[addr_rd_q];
      dec_src_instr = dec_from_fifo ? ib_instr_q[ib_rd_q] : IMEM_RDATA;
   end

   assign IMEM_REQ  = issue;
   assign IMEM_ADDR = pc_f_q;
   assign InstrD    = dec_instr_q;
   assign PC_DE     = dec_pc_q;
   assign VALID_D   = dec_valid_q;

   always_comb begin
      pc_f_d      = pc_f_q;
      addr_mem_d  = addr_mem_q;
      addr_wr_d   = addr_wr_q;
      addr_rd_d   = addr_rd_q;
      ib_pc_d     = ib_pc_q;
      ib_instr_d  = ib_instr_q;
      ib_wr_d     = ib_wr_q;
      ib_rd_d     = ib_rd_q;
      ib_cnt_d    = ib_cnt_q;
      in_flight_d = in_flight_q;
      drop_d      = drop_q;
      dec_instr_d = dec_instr_q;
      dec_pc_d    = dec_pc_q;
      dec_valid_d = dec_valid_q;

      if (BRN_TAKEN) begin
         pc_f_d      = BRN_TARGET & ~32'h3;
         addr_wr_d   = '0;
         addr_rd_d   = '0;
         ib_wr_d     = '0;
         ib_rd_d     = '0;
         ib_cnt_d    = '0;
         in_flight_d = in_flight_q - CntW'(resp);
         // Everything still outstanding after this cycle belongs to the old path.
         drop_d      = in_flight_q - CntW'(resp);
         dec_instr_d = NopInstr;
         dec_valid_d = 1'b0;
      end else begin
         if (accept) begin
            addr_mem_d[addr_wr_q] = pc_f_q;
            addr_wr_d             = addr_wr_q + 1'b1;
            pc_f_d                = pc_f_q + 32'd4;
         end
         if (resp_keep) begin
            addr_rd_d = addr_rd_q + 1'b1;
         end
         if (ib_push) begin
            ib_pc_d[ib_wr_q]    = addr_mem_q[addr_rd_q];
            ib_instr_d[ib_wr_q] = IMEM_RDATA;
            ib_wr_d             = ib_wr_q + 1'b1;
         end
         if (ib_pop) begin
            ib_rd_d = ib_rd_q + 1'b1;
         end
         ib_cnt_d    = ib_cnt_q + CntW'(ib_push) - CntW'(ib_pop);
         in_flight_d = in_flight_q + CntW'(accept) - CntW'(resp);
         if (resp_drop) begin
            drop_d = drop_q - 1'b1;
         end
         if (dec_load) begin
            if (dec_real) begin
               dec_instr_d = dec_src_instr;
               dec_pc_d    = dec_src_pc;
               dec_valid_d = 1'b1;
            end else begin
               dec_instr_d = NopInstr;
               dec_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_f_q      <= RESET_PC;
         addr_wr_q   <= '0;
         addr_rd_q   <= '0;
         ib_wr_q     <= '0;
         ib_rd_q     <= '0;
         ib_cnt_q    <= '0;
         in_flight_q <= '0;
         drop_q      <= '0;
         dec_instr_q <= NopInstr;
         dec_pc_q    <= 32'h0000_0000;
         dec_valid_q <= 1'b0;
      end else begin
         pc_f_q      <= pc_f_d;
         addr_wr_q   <= addr_wr_d;
         addr_rd_q   <= addr_rd_d;
         ib_wr_q     <= ib_wr_d;
         ib_rd_q     <= ib_rd_d;
         ib_cnt_q    <= ib_cnt_d;
         in_flight_q <= in_flight_d;
         drop_q      <= drop_d;
         dec_instr_q <= dec_instr_d;
         dec_pc_q    <= dec_pc_d;
         dec_valid_q <= dec_valid_d;
      end
   end

   // FIFO storage needs no reset; occupancy is tracked by the pointers and counters.
   always_ff @(posedge clk) begin
      addr_mem_q <= addr_mem_d;
      ib_pc_q    <= ib_pc_d;
      ib_instr_q <= ib_instr_d;
   end

`ifdef FETCH_MISALIGN_CHK_EN
   logic mis_flag_q, mis_flag_d;
   logic mis_out_q, mis_out_d;

   always_comb begin
      mis_flag_d = mis_flag_q;
      mis_out_d  = mis_out_q;
      if (BRN_TAKEN) begin
         mis_flag_d = |BRN_TARGET[1:0];
         mis_out_d  = 1'b0;
      end else if (dec_load) begin
         if (dec_real) begin
            mis_out_d  = mis_flag_q;
            mis_flag_d = 1'b0;
         end else begin
            mis_out_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mis_flag_q <= 1'b0;
         mis_out_q  <= 1'b0;
      end else begin
         mis_flag_q <= mis_flag_d;
         mis_out_q  <= mis_out_d;
      end
   end

   assign MISALIGN_D = mis_out_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a queue-based fixed-latency IMEM model
// whose response data equals the request address.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_RDY;
   logic        IMEM_VALID;
   logic [31:0] IMEM_RDATA;
   logic        STALL_D;
   logic        BRN_TAKEN;
   logic [31:0] BRN_TARGET;
   logic [31:0] InstrD;
   logic [31:0] PC_DE;
   logic        VALID_D;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        MISALIGN_D;
`endif

   int checks = 0;
   int fails  = 0;
   int lat    = 1;
   int mcyc   = 0;
   logic [31:0] mq_addr [$];
   int          mq_due  [$];

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .IMEM_REQ   (IMEM_REQ),
      .IMEM_ADDR  (IMEM_ADDR),
      .IMEM_RDY   (IMEM_RDY),
      .IMEM_VALID (IMEM_VALID),
      .IMEM_RDATA (IMEM_RDATA),
      .STALL_D    (STALL_D),
      .BRN_TAKEN  (BRN_TAKEN),
      .BRN_TARGET (BRN_TARGET),
      .InstrD     (InstrD),
      .PC_DE      (PC_DE),
`ifdef FETCH_MISALIGN_CHK_EN
      .MISALIGN_D (MISALIGN_D),
`endif
      .VALID_D    (VALID_D)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: accepts at mid-cycle, answers in order exactly lat cycles later.
   initial begin
      IMEM_VALID = 1'b0;
      IMEM_RDATA = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         mcyc++;
         IMEM_VALID = 1'b0;
         if (mq_due.size() > 0 && mq_due[0] <= mcyc) begin
            IMEM_VALID = 1'b1;
            IMEM_RDATA = mq_addr.pop_front();
            void'(mq_due.pop_front());
         end
         @(negedge clk);
         if (rst) begin
            mq_addr.delete();
            mq_due.delete();
         end else if (IMEM_REQ && IMEM_RDY) begin
            mq_addr.push_back(IMEM_ADDR);
            mq_due.push_back(mcyc + lat);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Leaves the bench at the start of cycle 0 (rst just released).
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      STALL_D = 1'b0;
      BRN_TAKEN = 1'b0;
      BRN_TARGET = 32'h0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      lat = 1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (IMEM_REQ !== 1'b0) begin fails++; $display("FAIL reset_req_in_rst got=%b exp=0", IMEM_REQ); end
      checks++; if (InstrD !== 32'h13) begin fails++; $display("FAIL reset_instr got=%h exp=00000013", InstrD); end
      checks++; if (PC_DE !== 32'h0) begin fails++; $display("FAIL reset_pc_de got=%h exp=0", PC_DE); end
      checks++; if (VALID_D !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", VALID_D); end
`ifdef FETCH_MISALIGN_CHK_EN
      checks++; if (MISALIGN_D !== 1'b0) begin fails++; $display("FAIL reset_misalign got=%b exp=0", MISALIGN_D); end
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (IMEM_REQ !== 1'b1) begin fails++; $display("FAIL reset_first_req got=%b exp=1", IMEM_REQ); end
      checks++; if (IMEM_ADDR !== 32'h0) begin fails++; $display("FAIL reset_first_addr got=%h exp=0", IMEM_ADDR); end
   endtask

   task automatic test_stream();
      logic [31:0] e;
      lat = 1;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         e = 32'(4 * c);
         checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== e) begin fails++; $display("FAIL stream_req c=%0d got=%b/%h exp=1/%h", c, IMEM_REQ, IMEM_ADDR, e); end
         if (c < 2) begin
            checks++; if (VALID_D !== 1'b0) begin fails++; $display("FAIL stream_bubble c=%0d got=%b exp=0", c, VALID_D); end
         end else begin
            e = 32'(4 * (c - 2));
            checks++; if (VALID_D !== 1'b1 || InstrD !== e || PC_DE !== e) begin fails++; $display("FAIL stream_dec c=%0d got=%b/%h/%h exp=1/%h/%h", c, VALID_D, InstrD, PC_DE, e, e); end
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp_instr [8];
      logic        exp_req   [8];
      exp_instr = '{32'h8, 32'h8, 32'h8, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
      exp_req   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      lat = 1;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         STALL_D = (c >= 4 && c <= 6);
         @(negedge clk);
         if (c >= 4) begin
            checks++; if (VALID_D !== 1'b1 || InstrD !== exp_instr[c-4] || PC_DE !== exp_instr[c-4]) begin fails++; $display("FAIL stall_dec c=%0d got=%b/%h/%h exp=1/%h", c, VALID_D, InstrD, PC_DE, exp_instr[c-4]); end
            checks++; if (IMEM_REQ !== exp_req[c-4]) begin fails++; $display("FAIL stall_req c=%0d got=%b exp=%b", c, IMEM_REQ, exp_req[c-4]); end
         end
         if (c == 4) begin
            checks++; if (IMEM_ADDR !== 32'h10) begin fails++; $display("FAIL stall_addr4 got=%h exp=10", IMEM_ADDR); end
         end
         if (c == 8) begin
            checks++; if (IMEM_ADDR !== 32'h14) begin fails++; $display("FAIL stall_addr8 got=%h exp=14", IMEM_ADDR); end
         end
      end
      STALL_D = 1'b0;
   endtask

   task automatic test_latency3();
      logic [31:0] exp_pc;
      int          ndel;
      int          outst;
      exp_pc = 32'h0;
      ndel = 0;
      lat = 3;
      do_reset();
      for (int c = 0; c < 30; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #2;
            outst = mq_addr.size() + int'(IMEM_VALID);
            checks++; if (outst > 2) begin fails++; $display("FAIL lat3_outstanding c=%0d got=%0d exp<=2", c, outst); end
         end
         @(negedge clk);
         if (c == 3) begin
            checks++; if (VALID_D !== 1'b0) begin fails++; $display("FAIL lat3_early c=3 got=%b exp=0", VALID_D); end
         end
         if (c == 4) begin
            checks++; if (VALID_D !== 1'b1 || PC_DE !== 32'h0) begin fails++; $display("FAIL lat3_first c=4 got=%b/%h exp=1/0", VALID_D, PC_DE); end
         end
         if (VALID_D === 1'b1) begin
            checks++; if (PC_DE !== exp_pc || InstrD !== exp_pc) begin fails++; $display("FAIL lat3_pair c=%0d got=%h/%h exp=%h", c, PC_DE, InstrD, exp_pc); end
            exp_pc = exp_pc + 32'd4;
            ndel++;
         end
      end
      checks++; if (ndel != 14) begin fails++; $display("FAIL lat3_count got=%0d exp=14", ndel); end
   endtask

   task automatic test_redirect();
      lat = 3;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         BRN_TAKEN = (c == 2);
         BRN_TARGET = 32'h100;
         @(negedge clk);
         if (c == 2) begin
            checks++; if (IMEM_REQ !== 1'b0) begin fails++; $display("FAIL redir_req_n got=%b exp=0", IMEM_REQ); end
         end
         if (c == 3) begin
            checks++; if (InstrD !== 32'h13) begin fails++; $display("FAIL redir_bubble got=%h exp=00000013", InstrD); end
         end
         if (c >= 3 && c <= 7) begin
            checks++; if (VALID_D !== 1'b0) begin fails++; $display("FAIL redir_drop c=%0d got=%b exp=0", c, VALID_D); end
         end
         if (c == 4) begin
            checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h100) begin fails++; $display("FAIL redir_target_req got=%b/%h exp=1/100", IMEM_REQ, IMEM_ADDR); end
         end
         if (c == 8) begin
            checks++; if (VALID_D !== 1'b1 || PC_DE !== 32'h100 || InstrD !== 32'h100) begin fails++; $display("FAIL redir_first got=%b/%h/%h exp=1/100/100", VALID_D, PC_DE, InstrD); end
         end
         if (c == 9) begin
            checks++; if (VALID_D !== 1'b1 || PC_DE !== 32'h104) begin fails++; $display("FAIL redir_second got=%b/%h exp=1/104", VALID_D, PC_DE); end
         end
      end
      BRN_TAKEN = 1'b0;
   endtask

   task automatic test_redirect_stall();
      lat = 1;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         BRN_TAKEN = (c == 4);
         STALL_D = (c == 4);
         BRN_TARGET = 32'h200;
         @(negedge clk);
         if (c == 4) begin
            checks++; if (IMEM_REQ !== 1'b0) begin fails++; $display("FAIL rs_req_n got=%b exp=0", IMEM_REQ); end
         end
         if (c == 5) begin
            checks++; if (VALID_D !== 1'b0 || InstrD !== 32'h13 || PC_DE !== 32'h8) begin fails++; $display("FAIL rs_bubble got=%b/%h/%h exp=0/00000013/8", VALID_D, InstrD, PC_DE); end
            checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h200) begin fails++; $display("FAIL rs_target_req got=%b/%h exp=1/200", IMEM_REQ, IMEM_ADDR); end
         end
         if (c == 6) begin
            checks++; if (VALID_D !== 1'b0 || IMEM_ADDR !== 32'h204) begin fails++; $display("FAIL rs_n2 got=%b/%h exp=0/204", VALID_D, IMEM_ADDR); end
         end
         if (c == 7) begin
            checks++; if (VALID_D !== 1'b1 || InstrD !== 32'h200 || PC_DE !== 32'h200) begin fails++; $display("FAIL rs_target got=%b/%h/%h exp=1/200/200", VALID_D, InstrD, PC_DE); end
         end
      end
      BRN_TAKEN = 1'b0;
      STALL_D = 1'b0;
   endtask

`ifdef FETCH_MISALIGN_CHK_EN
   task automatic test_misalign();
      lat = 1;
      do_reset();
      for (int c = 0; c < 9; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         BRN_TAKEN = (c == 4);
         BRN_TARGET = 32'h102;
         @(negedge clk);
         if (c == 5) begin
            checks++; if (IMEM_ADDR !== 32'h100 || MISALIGN_D !== 1'b0) begin fails++; $display("FAIL mis_addr got=%h/%b exp=100/0", IMEM_ADDR, MISALIGN_D); end
         end
         if (c == 7) begin
            checks++; if (PC_DE !== 32'h100 || MISALIGN_D !== 1'b1) begin fails++; $display("FAIL mis_first got=%h/%b exp=100/1", PC_DE, MISALIGN_D); end
         end
         if (c == 8) begin
            checks++; if (PC_DE !== 32'h104 || MISALIGN_D !== 1'b0) begin fails++; $display("FAIL mis_second got=%h/%b exp=104/0", PC_DE, MISALIGN_D); end
         end
      end
      BRN_TAKEN = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1;
      IMEM_RDY = 1'b1;
      STALL_D = 1'b0;
      BRN_TAKEN = 1'b0;
      BRN_TARGET = 32'h0;
      test_reset();
      test_stream();
      test_stall();
      test_latency3();
      test_redirect();
      test_redirect_stall();
`ifdef FETCH_MISALIGN_CHK_EN
      test_misalign();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
